fm_zc_demod: RTL and testbench

Zero-crossing FM demodulator: the receive-side counterpart of the NCO-based FM modulator. It consumes the 8-bit signed sine samples the modulator produces, one per clock, and measures the clock count between accepted rising zero crossings. It converts that period into a 32-bit frequency control word in the same units as the modulator's `ctrl` input, so `freq = clk * freq_out / 2^32`. It sits directly after the sample source in the loopback/demod path.

---
 rtl/fm_zc_demod.sv | 111 +++++++++++
 tb/tb_fm_zc_demod.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fm_zc_demod.sv
// Zero-crossing FM demodulator: measures clocks between accepted rising zero crossings
// and converts the period into a control word floor(2^32 / period) with a serial divider.
module fm_zc_demod #(
    parameter int unsigned HYST       = 8,
    parameter int unsigned MIN_PERIOD = 40,
    parameter logic [31:0] TIMEOUT    = 32'd1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sin_in,
    output logic [31:0] freq_out,
    output logic        freq_valid,
    output logic [31:0] period_out,
    output logic        locked,
    output logic        busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] DIV  = 1'b1;

    localparam logic signed [8:0] NEG_HYST = -$signed(9'(HYST));
    localparam logic [31:0] CNT_MAX = TIMEOUT - 32'd1;
    localparam logic [31:0] CNT_PRE = TIMEOUT - 32'd2;
    localparam logic [31:0] MIN_P   = 32'(MIN_PERIOD);

    logic [0:0]  state;
    logic [31:0] cnt;
    logic        armed;
    logic        have_ref;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [4:0]  iter;

    logic        arm;
    logic        crossing;
    logic        accept;
    logic        timeout;
    logic [31:0] period;
    logic [32:0] trial;
    logic        fits;

    always_comb begin
        arm      = $signed({sin_in[7], sin_in}) <= NEG_HYST;
        crossing = armed && !sin_in[7];
        period   = cnt + 32'd1;
        accept   = crossing && (period >= MIN_P);
        // Fires on the edge where cnt would step onto TIMEOUT-1.
        timeout  = have_ref && !accept && (cnt == CNT_PRE);
        trial    = rem << 1;
        fits     = trial >= {1'b0, period_out};
        busy     = (state == DIV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            armed      <= 1'b0;
            have_ref   <= 1'b0;
            rem        <= '0;
            quo        <= '0;
            iter       <= '0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
            period_out <= '0;
            locked     <= 1'b0;
        end else begin
            freq_valid <= 1'b0;

            if (arm)
                armed <= 1'b1;
            else if (crossing)
                armed <= 1'b0;

            if (accept)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 32'd1;

            if (accept) begin
                have_ref <= 1'b1;
                if (have_ref) begin
                    period_out <= period;
                    locked     <= 1'b1;
                    // Dividend 2^32: its top bit is preloaded, 32 bits remain to shift in.
                    rem        <= 33'd1;
                    quo        <= '0;
                    iter       <= '0;
                    state      <= DIV;
                end
            end else if (state == DIV) begin
                rem  <= fits ? (trial - {1'b0, period_out}) : trial;
                quo  <= {quo[30:0], fits};
                iter <= iter + 5'd1;
                if (iter == 5'd31) begin
                    freq_out   <= {quo[30:0], fits};
                    freq_valid <= 1'b1;
                    state      <= IDLE;
                end
            end

            if (timeout) begin
                have_ref   <= 1'b0;
                locked     <= 1'b0;
                freq_out   <= '0;
                freq_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fm_zc_demod.sv
// Scoreboard bench for fm_zc_demod: directed sample streams push hand-computed results,
// a monitor pops and compares on every freq_valid pulse.
module tb_fm_zc_demod;

    localparam logic [7:0] POS = 8'h32;  // +50
    localparam logic [7:0] NEG = 8'hCE;  // -50

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sin_in;
    logic [31:0] freq_out;
    logic        freq_valid;
    logic [31:0] period_out;
    logic        locked;
    logic        busy;

    typedef struct {
        logic [31:0] freq;
        logic [31:0] period;
        bit          lock;
        bit          is_div;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   busy_run   = 0;
    int   valid_seen = 0;

    fm_zc_demod #(
        .HYST(8),
        .MIN_PERIOD(40),
        .TIMEOUT(32'd256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sin_in(sin_in),
        .freq_out(freq_out),
        .freq_valid(freq_valid),
        .period_out(period_out),
        .locked(locked),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: outputs sampled on the falling edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (freq_valid) begin
            valid_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pulse with freq_out 0x%08h required no pulse", freq_out);
            end else begin
                e = sb.pop_front();
                check("freq_out", freq_out, e.freq);
                check("period_out", period_out, e.period);
                check("locked", 32'(locked), 32'(e.lock));
                check("busy_cycles", 32'(busy_run), e.is_div ? 32'd32 : 32'd0);
            end
        end
        if (busy)
            busy_run++;
        else
            busy_run = 0;
    end

    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        sin_in = v;
    endtask

    task automatic drive_n(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++)
            drive(v);
    endtask

    // One period of n samples, starting with the rising-crossing sample.
    task automatic cycle(input int n, input bit meas, input logic [31:0] f, input logic [31:0] p);
        if (meas)
            sb.push_back('{f, p, 1'b1, 1'b1});
        drive(POS);
        drive_n(POS, n / 2 - 1);
        drive_n(NEG, n / 2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1);
    end

    initial begin : stim
        int v0;
        rst    = 1'b1;
        sin_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_freq_out", freq_out, 32'd0);
        check("rst_freq_valid", 32'(freq_valid), 32'd0);
        check("rst_period_out", period_out, 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Period 64: exact power of two
        drive_n(NEG, 60);
        cycle(64, 1'b0, '0, '0);
        check("locked_after_first", 32'(locked), 32'd0);
        repeat (3) cycle(64, 1'b1, 32'h0400_0000, 32'd64);

        // Period 100
        cycle(100, 1'b1, 32'h0400_0000, 32'd64);
        repeat (2) cycle(100, 1'b1, 32'h028F_5C28, 32'd100);

        // Glitch 10 clocks after an accepted crossing
        sb.push_back('{32'h028F_5C28, 32'd100, 1'b1, 1'b1});
        drive(POS);
        drive_n(POS, 9);
        drive(8'hEC);
        drive(POS);
        drive(POS);
        check("period_after_glitch", period_out, 32'd100);
        check("locked_after_glitch", 32'(locked), 32'd1);
        drive_n(POS, 37);
        drive_n(NEG, 50);
        cycle(100, 1'b1, 32'h028F_5C28, 32'd100);

        // Timeout: hold zero after a measuring crossing
        sb.push_back('{32'h028F_5C28, 32'd100, 1'b1, 1'b1});
        sb.push_back('{32'd0, 32'd100, 1'b0, 1'b0});
        drive(POS);
        drive_n(8'h00, 255);
        check("locked_before_timeout", 32'(locked), 32'd1);
        drive(8'h00);
        check("locked_at_timeout", 32'(locked), 32'd0);
        check("freq_out_at_timeout", freq_out, 32'd0);
        check("valid_at_timeout", 32'(freq_valid), 32'd1);
        check("period_at_timeout", period_out, 32'd100);

        // Relock needs two crossings
        drive_n(NEG, 60);
        cycle(100, 1'b0, '0, '0);
        check("locked_after_relock_first", 32'(locked), 32'd0);
        cycle(100, 1'b1, 32'h028F_5C28, 32'd100);

        // Hysteresis: +-5 never arms
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        v0 = valid_seen;
        repeat (150) begin
            drive(8'hFB);
            drive(8'h05);
        end
        check("hyst_locked", 32'(locked), 32'd0);
        check("hyst_no_valid", 32'(valid_seen), 32'(v0));

        // Reset during division at E+10
        drive_n(NEG, 60);
        cycle(64, 1'b0, '0, '0);
        drive(POS);
        drive_n(POS, 9);
        @(negedge clk);
        check("busy_before_rst", 32'(busy), 32'd1);
        check("period_before_rst", period_out, 32'd64);
        rst    = 1'b1;
        sin_in = POS;
        @(negedge clk);
        check("midrst_freq_out", freq_out, 32'd0);
        check("midrst_freq_valid", 32'(freq_valid), 32'd0);
        check("midrst_period_out", period_out, 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        drive_n(NEG, 60);
        cycle(64, 1'b0, '0, '0);
        check("locked_before_second", 32'(locked), 32'd0);
        cycle(64, 1'b1, 32'h0400_0000, 32'd64);
        drive_n(NEG, 40);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
